// File: rtl/stripe_pkg.sv
// stripe_pkg: constants and types shared by the stripe scheduler, the two-lane
// byte striper and the un-striper.
//   DATA_W, BURST_LEN : default word width and maximum grant window (even, >= 2)
//   LANE0, LANE1      : values of the lane/phase bit
//   state_t           : scheduler FSM encoding
//   grant_of()        : one-hot grant vector that a scheduler state presents
package stripe_pkg;

  localparam int DATA_W    = 32;
  localparam int BURST_LEN = 4;

  localparam logic LANE0 = 1'b0;
  localparam logic LANE1 = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_GRANT0,
    ST_GRANT1,
    ST_PAD
  } state_t;

  function automatic logic [1:0] grant_of(state_t s);
    case (s)
      ST_GRANT0: return 2'b01;
      ST_GRANT1: return 2'b10;
      default:   return 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// rr_arbiter2: two-way round-robin arbiter.
//   clk_2f  : clock
//   reset_L : asynchronous active-low reset
//   req     : request vector, bit i = requester i
//   en      : arbitration allowed this cycle
//   gnt     : one-hot grant, 00 when en is low or nothing is requested
// On a tie the requester that did not win last time is granted; a sole
// requester always wins. last_grant resets to 1 so requester 0 wins the
// first tie.
module rr_arbiter2 (
  input  logic       clk_2f,
  input  logic       reset_L,
  input  logic [1:0] req,
  input  logic       en,
  output logic [1:0] gnt
);

  logic last_grant;  // index of the most recent winner

  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    gnt = 2'b00;
    if (en) begin
      if (req == 2'b11) gnt = last_grant ? 2'b01 : 2'b10;
      else              gnt = req;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk_2f or negedge reset_L) begin
    if (!reset_L)  last_grant <= 1'b1;
    else if (|gnt) last_grant <= gnt[1];
  end

endmodule

// File: rtl/stripe_scheduler.sv
// stripe_scheduler: grants one of two requesters at a time for a bounded burst
// and presents the granted words as one registered valid/data stream for the
// two-lane striper. Bursts start on lane 0 and occupy an even number of slots.
//   clk_2f, reset_L          : clock, asynchronous active-low reset
//   reqN_data/valid/last     : requester N word, word available, final word
//   reqN_ready               : requester N word accepted when valid & ready
//   data_out, valid_out      : registered accepted word (zero on bubbles)
//   phase                    : lane of the current data_out word
//   grant                    : registered one-hot owner of the current window
module stripe_scheduler #(
  parameter int DATA_W    = stripe_pkg::DATA_W,
  parameter int BURST_LEN = stripe_pkg::BURST_LEN
) (
  input  logic              clk_2f,
  input  logic              reset_L,
  input  logic [DATA_W-1:0] req0_data,
  input  logic              req0_valid,
  input  logic              req0_last,
  output logic              req0_ready,
  input  logic [DATA_W-1:0] req1_data,
  input  logic              req1_valid,
  input  logic              req1_last,
  output logic              req1_ready,
  output logic [DATA_W-1:0] data_out,
  output logic              valid_out,
  output logic              phase,
  output logic [1:0]        grant
);

  import stripe_pkg::*;

  localparam int CNT_W = $clog2(BURST_LEN + 1);

  state_t            state, state_next;
  logic [CNT_W-1:0]  cnt, cnt_next, win_pos;
  logic [1:0]        arb_gnt;
  logic              arb_en;
  logic              acc0, acc1, acc_last, in_window;
  logic [DATA_W-1:0] acc_data;

  rr_arbiter2 u_arb (
    .clk_2f  (clk_2f),
    .reset_L (reset_L),
    .req     ({req1_valid, req0_valid}),
    .en      (arb_en),
    .gnt     (arb_gnt)
  );

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    arb_en     = 1'b0;
    req0_ready = 1'b0;
    req1_ready = 1'b0;

    case (state)
      ST_IDLE: begin
        // Arbitrate only when the next emitted word lands in lane 0.
        arb_en     = (phase == LANE1);
        req0_ready = arb_gnt[0];
        req1_ready = arb_gnt[1];
        if (|arb_gnt) state_next = arb_gnt[0] ? ST_GRANT0 : ST_GRANT1;
      end
      ST_GRANT0: req0_ready = 1'b1;
      ST_GRANT1: req1_ready = 1'b1;
      default:   state_next = ST_IDLE;  // ST_PAD: one bubble, then realign
    endcase

    acc0     = req0_valid & req0_ready;
    acc1     = req1_valid & req1_ready;
    acc_last = (acc0 & req0_last) | (acc1 & req1_last);
    acc_data = acc0 ? req0_data : (acc1 ? req1_data : '0);

    // win_pos is the 1-based window cycle being spent now; the IDLE grant
    // cycle is window cycle 1. A last accepted there closes a one-slot window.
    win_pos   = (state == ST_IDLE) ? CNT_W'(1) : cnt + 1'b1;
    in_window = (state == ST_GRANT0) || (state == ST_GRANT1) || (|arb_gnt);
    if (in_window) begin
      if (acc_last || win_pos == CNT_W'(BURST_LEN)) begin
        // An odd-length window leaves the stream on lane 1; pad to realign.
        state_next = win_pos[0] ? ST_PAD : ST_IDLE;
        cnt_next   = '0;
      end else begin
        cnt_next = win_pos;
      end
    end
  end

  always_ff @(posedge clk_2f or negedge reset_L) begin
    if (!reset_L) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      phase     <= LANE0;
      data_out  <= '0;
      valid_out <= 1'b0;
      grant     <= 2'b00;
    end else begin
      state     <= state_next;
      cnt       <= cnt_next;
      phase     <= ~phase;  // tracks the striper's lane counter
      data_out  <= acc_data;
      valid_out <= acc0 | acc1;
      grant     <= grant_of(state_next);
    end
  end

endmodule

// File: tb/tb_stripe_scheduler.sv
// tb_stripe_scheduler: directed and randomized stimulus for stripe_scheduler,
// checked every cycle against a transaction-level reference model.
module tb_stripe_scheduler;

  localparam int DATA_W    = 32;
  localparam int BURST_LEN = 4;

  typedef struct {
    logic [DATA_W-1:0] data;
    bit                last;
    bit                gap;   // hold valid low for one cycle before this word
  } word_t;

  typedef struct {
    bit                valid;
    logic [DATA_W-1:0] data;
    bit                phase;
  } obs_t;

  logic              clk_2f  = 1'b0;
  logic              reset_L = 1'b1;
  logic              req0_ready, req1_ready;
  logic [DATA_W-1:0] data_out;
  logic              valid_out, phase;
  logic [1:0]        grant;

  logic [1:0]        in_valid = 2'b00;
  logic [1:0]        in_last  = 2'b00;
  logic [DATA_W-1:0] in_data [2];

  word_t q0[$], q1[$];
  obs_t  stream[$];
  int    exp_q[$];
  int    stall_pct = 0;
  int    n_checks  = 0;
  int    n_fail    = 0;

  // reference model state
  int                m_owner, m_used, m_last, m_acc;
  bit                m_pad, m_phase, m_valid;
  logic [DATA_W-1:0] m_data;
  logic [1:0]        m_grant, m_rdy;

  stripe_scheduler #(.DATA_W(DATA_W), .BURST_LEN(BURST_LEN)) dut (
    .clk_2f     (clk_2f),
    .reset_L    (reset_L),
    .req0_data  (in_data[0]),
    .req0_valid (in_valid[0]),
    .req0_last  (in_last[0]),
    .req0_ready (req0_ready),
    .req1_data  (in_data[1]),
    .req1_valid (in_valid[1]),
    .req1_last  (in_last[1]),
    .req1_ready (req1_ready),
    .data_out   (data_out),
    .valid_out  (valid_out),
    .phase      (phase),
    .grant      (grant)
  );

  always #5 clk_2f = ~clk_2f;

  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic push(int r, logic [DATA_W-1:0] data, bit last, bit gap);
    word_t w;
    w.data = data; w.last = last; w.gap = gap;
    if (r == 0) q0.push_back(w);
    else        q1.push_back(w);
  endtask

  task automatic push_xfer(int r, int base, int n);
    for (int i = 0; i < n; i++) push(r, DATA_W'(base + i), i == n - 1, 1'b0);
  endtask

  task automatic model_reset();
    m_owner = -1; m_used = 0; m_last = 1; m_pad = 1'b0; m_phase = 1'b0;
    m_valid = 1'b0; m_data = '0; m_grant = 2'b00; m_rdy = 2'b00;
  endtask

  // One cycle of the scheduler rules, applied to the inputs now on the wires.
  task automatic model_cycle();
    int w;
    m_rdy = 2'b00;
    m_acc = -1;
    if (m_pad) begin
      m_pad = 1'b0;
    end else if (m_owner < 0 && m_phase && in_valid != 2'b00) begin
      if (in_valid == 2'b11) w = 1 - m_last;
      else                   w = in_valid[0] ? 0 : 1;
      m_owner = w; m_last = w; m_used = 0;
    end
    if (m_owner >= 0) begin
      m_rdy[m_owner] = 1'b1;
      m_used++;
      if (in_valid[m_owner]) m_acc = m_owner;
      if ((m_acc >= 0 && in_last[m_owner]) || m_used == BURST_LEN) begin
        m_pad   = (m_used % 2 == 1);
        m_owner = -1;
      end
    end
    m_valid = (m_acc >= 0);
    m_data  = (m_acc >= 0) ? in_data[m_acc] : '0;
    m_grant = (m_owner >= 0) ? 2'(1 << m_owner) : 2'b00;
    m_phase = ~m_phase;
  endtask

  task automatic drive_inputs();
    word_t h;
    bit    have;
    for (int r = 0; r < 2; r++) begin
      have        = (r == 0) ? (q0.size() != 0) : (q1.size() != 0);
      in_valid[r] = 1'b0;
      in_data[r]  = $urandom;
      in_last[r]  = 1'($urandom_range(0, 1));  // junk last with valid low
      if (have) begin
        h = (r == 0) ? q0[0] : q1[0];
        if (h.gap) begin
          if (r == 0) q0[0].gap = 1'b0;
          else        q1[0].gap = 1'b0;
        end else if ($urandom_range(0, 99) >= stall_pct) begin
          in_valid[r] = 1'b1;
          in_data[r]  = h.data;
          in_last[r]  = h.last;
        end
      end
    end
  endtask

  task automatic step();
    obs_t o;
    bit   acc0, acc1;
    @(negedge clk_2f);
    check("data_out", data_out, m_data);
    check("valid_out", valid_out, m_valid);
    check("phase", phase, m_phase);
    check("grant", grant, m_grant);
    o.valid = valid_out; o.data = data_out; o.phase = phase;
    stream.push_back(o);
    drive_inputs();
    #1;
    model_cycle();
    check("req0_ready", req0_ready, m_rdy[0]);
    check("req1_ready", req1_ready, m_rdy[1]);
    acc0 = in_valid[0] & req0_ready;
    acc1 = in_valid[1] & req1_ready;
    @(posedge clk_2f);
    if (acc0) void'(q0.pop_front());
    if (acc1) void'(q1.pop_front());
  endtask

  task automatic drain(int budget);
    int n = 0;
    while ((q0.size() != 0 || q1.size() != 0 || m_owner >= 0 || m_pad) && n < budget) begin
      step();
      n++;
    end
    check("drain_in_budget", n < budget, 1);
    repeat (2) step();
  endtask

  // Hold reset for the given cycles with the queued requesters presenting.
  task automatic apply_reset(int cycles);
    reset_L = 1'b0;
    model_reset();
    repeat (cycles) begin
      @(negedge clk_2f);
      drive_inputs();
      #1;
      check("rst_valid_out", valid_out, 0);
      check("rst_data_out", data_out, 0);
      check("rst_grant", grant, 0);
      check("rst_phase", phase, 0);
      check("rst_ready0", req0_ready, 0);
      check("rst_ready1", req1_ready, 0);
    end
    @(posedge clk_2f);
    #2 reset_L = 1'b1;
  endtask

  // Compares the emitted stream from its first valid slot against exp_q
  // (-1 = bubble) and checks that the first word and word ph_idx are lane 0.
  task automatic check_stream(string tag, int ph_idx);
    int i0 = -1;
    int got;
    for (int i = 0; i < stream.size(); i++) if (i0 < 0 && stream[i].valid) i0 = i;
    check({tag, "_found"}, i0 >= 0, 1);
    if (i0 >= 0) begin
      for (int k = 0; k < exp_q.size(); k++) begin
        if (i0 + k >= stream.size()) got = -2;
        else got = stream[i0 + k].valid ? int'(stream[i0 + k].data) : -1;
        check($sformatf("%s_slot%0d", tag, k), got, exp_q[k]);
      end
      check({tag, "_first_lane"}, stream[i0].phase, 0);
      got = (i0 + ph_idx < stream.size()) ? int'(stream[i0 + ph_idx].phase) : 1;
      check($sformatf("%s_lane_slot%0d", tag, ph_idx), got, 0);
    end
  endtask

  initial begin
    int nv, n;

    // Reset with both requesters valid, then tie arbitration from reset.
    push_xfer(0, 'h10, 4);
    push_xfer(0, 'h14, 4);
    push_xfer(1, 'h20, 4);
    apply_reset(3);
    stream.delete();
    drain(200);
    exp_q = '{'h10, 'h11, 'h12, 'h13, 'h20, 'h21, 'h22, 'h23, 'h14, 'h15, 'h16, 'h17};
    check_stream("tie", 8);

    // Single requester, 6 words across two windows.
    push_xfer(0, 'hA0, 6);
    stream.delete();
    drain(200);
    exp_q = '{'hA0, 'hA1, 'hA2, 'hA3, 'hA4, 'hA5};
    check_stream("single", 4);

    // Odd transfer followed by another transfer from the same requester.
    push_xfer(1, 'hB0, 3);
    push_xfer(1, 'hB4, 2);
    stream.delete();
    drain(200);
    exp_q = '{'hB0, 'hB1, 'hB2, -1, 'hB4, 'hB5};
    check_stream("odd", 4);

    // Stall after the 2nd word; the window still closes after 4 cycles.
    push(0, 'hD0, 1'b0, 1'b0);
    push(0, 'hD1, 1'b0, 1'b0);
    push(0, 'hD2, 1'b0, 1'b1);
    push(0, 'hD3, 1'b0, 1'b0);
    push(0, 'hD4, 1'b1, 1'b0);
    stream.delete();
    drain(200);
    exp_q = '{'hD0, 'hD1, -1, 'hD2, 'hD3, 'hD4};
    check_stream("stall", 4);

    // Randomized traffic with requester stalls.
    stall_pct = 25;
    for (int round = 0; round < 30; round++) begin
      for (int t = 0; t < $urandom_range(1, 3); t++) begin
        int r   = $urandom_range(0, 1);
        int len = $urandom_range(1, 7);
        for (int i = 0; i < len; i++) push(r, $urandom, i == len - 1, 1'b0);
      end
      drain(1000);
    end
    stall_pct = 0;

    // Reset in the middle of a req1 burst.
    push_xfer(1, 'hE0, 4);
    stream.delete();
    nv = 0;
    n  = 0;
    while (nv < 2 && n < 50) begin
      step();
      n++;
      nv = 0;
      foreach (stream[i]) if (stream[i].valid) nv++;
    end
    check("midrst_two_words", nv, 2);
    #3 reset_L = 1'b0;
    q0.delete();
    q1.delete();
    push_xfer(1, 'hE0, 4);
    push_xfer(0, 'hF0, 4);
    #1;
    check("midrst_async_valid", valid_out, 0);
    check("midrst_async_data", data_out, 0);
    check("midrst_async_grant", grant, 0);
    check("midrst_async_ready1", req1_ready, 0);
    apply_reset(2);
    stream.delete();
    drain(200);
    exp_q = '{'hF0, 'hF1, 'hF2, 'hF3, 'hE0, 'hE1, 'hE2, 'hE3};
    check_stream("midrst", 4);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  // Hard stop in case the stimulus itself stalls.
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/stripe_scheduler.md
# stripe_scheduler

Two-requester burst scheduler sitting directly upstream of the two-lane byte striper, in the `clk_2f` domain. It grants one requester at a time for a bounded burst and presents that requester's words as a single registered valid/data stream. Every burst starts on lane 0 and occupies an even number of stream slots, so the two lanes stay pair-aligned for the downstream un-striper.

## Interface
- `DATA_W`, 32, word width; must match the striper data width.
- `BURST_LEN`, 4, maximum grant window in cycles; even, ≥2.
- `clk_2f` in 1: the single clock, shared with the striper.
- `reset_L` in 1: asynchronous, active-low reset. One clock; no other reset.
- `req0_data` in DATA_W: requester 0 word.
- `req0_valid` in 1: requester 0 word available.
- `req0_last` in 1: marks the final word of requester 0's transfer; qualified by `req0_valid`.
- `req0_ready` out 1: requester 0 word is accepted when `req0_valid & req0_ready` at a rising edge.
- `req1_data`, `req1_valid`, `req1_last`, `req1_ready`: same as requester 0.
- `data_out` out DATA_W: drives the striper `data_in`.
- `valid_out` out 1: drives the striper `valid_in`.
- `phase` out 1: lane that the current `data_out` word lands in; 0 = lane_0, 1 = lane_1.
- `grant` out 2: one-hot owner of the current window; 00 when none.

## Operation
- `phase` toggles every cycle, unconditionally, and mirrors the striper's internal lane counter.
- FSM states: IDLE, GRANT0, GRANT1, PAD.
- **IDLE**
  - When `phase==1` and any `reqX_valid` is high, the round-robin arbiter picks a winner.
  - The winner's `ready` is asserted combinationally in that same cycle, so its first word is accepted.
  - State moves to GRANTX with `cnt=1`.
  - When `phase==0`, or no requester is valid: both `ready` signals are 0 and state stays IDLE.
- **GRANTX**
  - `reqX_ready=1`; the other requester's `ready` is 0.
  - `cnt` counts window cycles, whether or not a word is accepted. Cycles without an accept emit a bubble.
  - The window ends on an accepted `last`, or when `cnt` reaches `BURST_LEN`.
  - If the end falls on an odd `cnt`, state moves to PAD; otherwise to IDLE.
- **PAD**: one cycle, both `ready=0`, bubble emitted; then IDLE.
- **Round-robin arbiter**
  - `last_grant` resets to 1, so requester 0 wins the first tie.
  - On a tie, the requester that did not win last gets the grant.
  - A sole valid requester is re-granted back-to-back.
- **Output stage**
  - `data_out` and `valid_out` are registered from the accepted word.
  - On any non-accept cycle: `valid_out=0` and `data_out=0`.
- **`grant`** is registered and reflects the state: GRANT0 gives 01, GRANT1 gives 10, IDLE and PAD give 00.
- **Reset values:** state IDLE, `phase=0`, `cnt=0`, `last_grant=1`, `data_out=0`, `valid_out=0`, `grant=00`. Both `ready` signals are 0 while `reset_L=0`.
- **Reset mid-burst:** the partial burst is discarded. Already-emitted words are not retracted; requesters resend the full transfer.
- **`last` with `valid` low** is ignored.

## Timing
- Latency: a word accepted at edge t appears on `data_out`/`valid_out` from edge t until edge t+1.
- A first accept happens only with `phase==1`, so the first burst word is emitted with `phase==0` (lane_0).
- An even window ends in a cycle with `phase==0`; the next cycle is `phase==1`, so the next grant follows with no gap.
- An odd window costs exactly one PAD bubble.
- Maximum sustained throughput is 1 word/cycle. The only bubbles are PAD slots, requester stalls, and at most one cycle of IDLE alignment wait.

## Structure
- Shared package `stripe_pkg` holds:
  - the FSM state encoding;
  - `LANE0`/`LANE1` constants;
  - `DATA_W` and `BURST_LEN` defaults, which the striper and un-striper also use.
- One sub-module, `rr_arbiter2`: 2-way round-robin arbiter with inputs `req[1:0]` and `en`, output one-hot `gnt[1:0]`, and an internal `last_grant` register.

## Test plan
- **Reset:** hold `reset_L=0` for 3 cycles with both requesters valid.
  - During reset: all outputs 0, both `ready=0`.
  - After release: first accept only in a `phase==1` cycle; the first word appears with `phase=0`.
- **Single requester, 6 words:** req0 sends 0xA0–0xA5 back-to-back, `last` on 0xA5, `BURST_LEN=4`.
  - Output: A0,A1,A2,A3 (window ends), then A4,A5 with no gap.
  - A0 and A4 land with `phase=0`.
- **Tie from reset:** both requesters valid, 4-word bursts, req0 = 0x1x, req1 = 0x2x.
  - `grant` sequence: 01, 10, 01.
  - Output: 10,11,12,13,20,21,22,23 with no bubbles.
- **Odd transfer:** req1 sends 3 words (0xB0–0xB2) with `last` on 0xB2.
  - Output: B0,B1,B2, then one `valid_out=0` slot (PAD).
  - The next burst starts at `phase=0`.
- **Requester stall:** req0 drops `valid` for one cycle after its 2nd word, `BURST_LEN=4`.
  - Window: word, word, bubble (`valid_out=0`, data 0), word.
  - The window closes after 4 cycles; the 4th word is carried into the next grant.
- **Reset mid-burst:** assert `reset_L=0` after req1's 2nd word.
  - Outputs clear asynchronously.
  - After release, the arbiter restarts with req0 preferred on a tie.
